// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
    StAluWb, StBranch, StJal, StJalr, StJalrLink, StLui, StAuipc, StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  localparam logic [1:0] RsAluOut    = 2'b00;
  localparam logic [1:0] RsData      = 2'b01;
  localparam logic [1:0] RsAluResult = 2'b10;
  localparam logic [1:0] RsImmExt    = 2'b11;

  localparam logic [1:0] SaPc    = 2'b00;
  localparam logic [1:0] SaOldPc = 2'b01;
  localparam logic [1:0] SaRd1   = 2'b10;

  localparam logic [1:0] SbRd2  = 2'b00;
  localparam logic [1:0] SbImm  = 2'b01;
  localparam logic [1:0] SbFour = 2'b10;

  localparam logic [1:0] AopAdd   = 2'b00;
  localparam logic [1:0] AopSub   = 2'b01;
  localparam logic [1:0] AopFunct = 2'b10;

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational opcode to immediate-type decode.
module imm_src_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W     = 7,
  parameter int unsigned IMMSRC_W = 3
) (
  input  logic [OP_W-1:0]     op,
  output logic [IMMSRC_W-1:0] imm_src
);

  always_comb begin
    imm_src = IMMSRC_W'(ImmI);
    case (op)
      OP_W'(OpLoad), OP_W'(OpImm), OP_W'(OpJalr): imm_src = IMMSRC_W'(ImmI);
      OP_W'(OpStore):                             imm_src = IMMSRC_W'(ImmS);
      OP_W'(OpBranch):                            imm_src = IMMSRC_W'(ImmB);
      OP_W'(OpJal):                               imm_src = IMMSRC_W'(ImmJ);
      OP_W'(OpLui), OP_W'(OpAuipc):               imm_src = IMMSRC_W'(ImmU);
      default:                                    imm_src = IMMSRC_W'(ImmI);
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore multicycle control FSM for RV32I with trap flag and retire counter.
// Define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W     = 7,
  parameter int unsigned IMMSRC_W = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op,
  input  logic                BranchTaken,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [IMMSRC_W-1:0] ImmSrc,
  output logic                illegal,
  output logic                retire,
  output logic [CNT_W-1:0]    retired_count
);

  state_e           state_q, state_d;
  logic             is_load_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  logic             pc_update, branch, mem_ok;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  imm_src_decoder #(
    .OP_W     (OP_W),
    .IMMSRC_W (IMMSRC_W)
  ) u_imm_src_decoder (
    .op      (op),
    .imm_src (ImmSrc)
  );

  always_comb begin
    state_d   = state_q;
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    retire    = 1'b0;
    ResultSrc = RsAluOut;
    ALUSrcA   = SaPc;
    ALUSrcB   = SbRd2;
    ALUOp     = AopAdd;
    unique case (state_q)
      StFetch: begin
        IRWrite   = mem_ok;
        pc_update = mem_ok;
        ALUSrcB   = SbFour;
        ResultSrc = RsAluResult;
        if (mem_ok) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = SaOldPc;
        ALUSrcB = SbImm;
        case (op)
          OP_W'(OpLoad), OP_W'(OpStore): state_d = StMemAdr;
          OP_W'(OpR):                    state_d = StExecR;
          OP_W'(OpImm):                  state_d = StExecI;
          OP_W'(OpBranch):               state_d = StBranch;
          OP_W'(OpJal):                  state_d = StJal;
          OP_W'(OpJalr):                 state_d = StJalr;
          OP_W'(OpLui):                  state_d = StLui;
          OP_W'(OpAuipc):                state_d = StAuipc;
          default:                       state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SaRd1;
        ALUSrcB = SbImm;
        state_d = is_load_q ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_ok) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = RsData;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ok;
        if (mem_ok) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA = SaRd1;
        ALUOp   = AopFunct;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = SaRd1;
        ALUSrcB = SbImm;
        ALUOp   = AopFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA = SaRd1;
        ALUOp   = AopSub;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StJal: begin
        ALUSrcA   = SaOldPc;
        ALUSrcB   = SbFour;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StJalr: begin
        ALUSrcA   = SaRd1;
        ALUSrcB   = SbImm;
        ResultSrc = RsAluResult;
        pc_update = 1'b1;
        state_d   = StJalrLink;
      end
      StJalrLink: begin
        ALUSrcA = SaOldPc;
        ALUSrcB = SbFour;
        state_d = StAluWb;
      end
      StLui: begin
        ResultSrc = RsImmExt;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StAuipc: begin
        ALUSrcA = SaOldPc;
        ALUSrcB = SbImm;
        state_d = StAluWb;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
    PCWrite = pc_update | (branch & BranchTaken);
  end

  // The load/store choice is latched in DECODE because op may change afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      is_load_q <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) is_load_q <= (op == OP_W'(OpLoad));
      if (state_d == StTrap) illegal_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign illegal       = illegal_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed and random opcodes against a per-instruction output model.
module tb_multicycle_controller;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    op;
  logic          BranchTaken, mem_ready;
  logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, retire;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]    ImmSrc;
  logic [CW-1:0] retired_count;

  int vectors     = 0;
  int miscompares = 0;
  int model_count = 0;

  multicycle_controller #(.OP_W(7), .IMMSRC_W(3), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .BranchTaken   (BranchTaken),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .ImmSrc        (ImmSrc),
    .illegal       (illegal),
    .retire        (retire),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  logic [13:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUOp, retire};

  localparam logic [13:0] FetchVec = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10,
                                      2'b00, 1'b0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ncyc(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b1100111:                         return 5;
      7'b1100011, 7'b0110111:                         return 3;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
      7'b0010111:                                     return 4;
      default:                                        return 2;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  // Expected outputs in cycle k (1-based) of an instruction with opcode o.
  function automatic logic [13:0] exp_vec(input logic [6:0] o, input int k, input logic bt);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ret = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, aop = 0;
    if (k == 1) begin
      irw = 1; pcw = 1; sb = 2; rs = 2;
    end else if (k == 2) begin
      sa = 1; sb = 1;
    end else begin
      case (o)
        7'b0000011: if (k == 3) begin sa = 2; sb = 1; end
                    else if (k == 4) adr = 1;
                    else begin rs = 1; rw = 1; ret = 1; end
        7'b0100011: if (k == 3) begin sa = 2; sb = 1; end
                    else begin adr = 1; mw = 1; ret = 1; end
        7'b0110011: if (k == 3) begin sa = 2; aop = 2; end else begin rw = 1; ret = 1; end
        7'b0010011: if (k == 3) begin sa = 2; sb = 1; aop = 2; end
                    else begin rw = 1; ret = 1; end
        7'b1100011: begin sa = 2; aop = 1; pcw = bt; ret = 1; end
        7'b1101111: if (k == 3) begin sa = 1; sb = 2; pcw = 1; end
                    else begin rw = 1; ret = 1; end
        7'b1100111: if (k == 3) begin sa = 2; sb = 1; rs = 2; pcw = 1; end
                    else if (k == 4) begin sa = 1; sb = 2; end
                    else begin rw = 1; ret = 1; end
        7'b0110111: begin rs = 3; rw = 1; ret = 1; end
        7'b0010111: if (k == 3) begin sa = 1; sb = 1; end else begin rw = 1; ret = 1; end
        default: ;
      endcase
    end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, ret};
  endfunction

  // Runs one instruction; op is scrambled after DECODE to prove it is ignored later.
  task automatic run_instr(input logic [6:0] o, input int force_bt);
    logic [6:0] cur;
    int n = ncyc(o);
    for (int k = 1; k <= n; k++) begin
      cur         = (k <= 2) ? o : 7'($urandom);
      op          = cur;
      BranchTaken = (force_bt >= 0) ? force_bt[0] : 1'($urandom);
`ifdef MEM_WAIT_EN
      mem_ready   = 1'b1;
`else
      mem_ready   = 1'($urandom);
`endif
      @(negedge clk);
      chk($sformatf("op%b_c%0d_outs", o, k), 32'(obs), 32'(exp_vec(o, k, BranchTaken)));
      chk($sformatf("op%b_c%0d_imm", o, k), 32'(ImmSrc), 32'(exp_imm(cur)));
      @(posedge clk);
      #1;
    end
    model_count = (model_count + 1) % (1 << CW);
    chk($sformatf("op%b_count", o), 32'(retired_count), 32'(model_count));
    chk($sformatf("op%b_illegal", o), 32'(illegal), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_count = 0;
    chk("reset_outs", 32'(obs), 32'(FetchVec));
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_count", 32'(retired_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [6:0] legal [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    op = 7'b0110011; BranchTaken = 0; mem_ready = 1;
    rst_n = 1'b1;
    #2;
    do_reset();

    run_instr(7'b0110011, -1);
    run_instr(7'b0000011, -1);
    run_instr(7'b1100011, 0);
    run_instr(7'b1100011, 1);
    run_instr(7'b1100111, -1);

    // Random mix long enough to wrap the narrow counter.
    for (int i = 0; i < 40; i++) run_instr(legal[$urandom_range(0, 8)], -1);

    // Illegal opcode: trap and hold.
    op = 7'b1111111; BranchTaken = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("trap_c%0d_outs", k), 32'(obs), 32'(exp_vec(7'b1111111, k, 1'b1)));
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 20; k++) begin
      op = 7'($urandom); BranchTaken = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      chk("trap_outs", 32'(obs), 32'd0);
      chk("trap_illegal", 32'(illegal), 32'd1);
      chk("trap_count", 32'(retired_count), 32'(model_count));
      @(posedge clk);
      #1;
    end
    do_reset();
    run_instr(7'b0110111, -1);

    // Reset in the middle of a load aborts it without retiring.
    op = 7'b0000011; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    run_instr(7'b0100011, -1);

`ifdef MEM_WAIT_EN
    op = 7'b0100011; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_fetch_irwrite", 32'(IRWrite), 32'd0);
      chk("stall_fetch_pcwrite", 32'(PCWrite), 32'd0);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("fetch_irwrite_pulse", 32'(IRWrite), 32'd1);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("decode_irwrite", 32'(IRWrite), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_memwrite", 32'({MemWrite, retire}), 32'b10);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("memwrite_done", 32'({MemWrite, retire}), 32'b11);
    @(posedge clk);
    #1;
    model_count = (model_count + 1) % (1 << CW);
    chk("memwrite_count", 32'(retired_count), 32'(model_count));
    run_instr(7'b0010011, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
